// File: rtl/online_mult_sequencer.sv
// Sequencer for the digit-serial online multiplier: master count, operand digit
// fetch with stall, zero-fill flush and CA_RAM address arbitration.
module online_mult_sequencer #(
    parameter int N_DIGITS = 32,
    parameter int DELTA    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [8:0] cnt_master,
    output logic       write_enable,
    output logic       digit_req,
    input  logic       digit_valid,
    output logic       zero_fill,
    output logic       out_digit_valid,
    input  logic [6:0] cc_addr,
    input  logic       rd_req,
    input  logic [6:0] rd_addr,
    output logic       rd_grant,
    output logic       rd_data_valid,
    output logic [6:0] ram_addr
);

    localparam logic [8:0] CNT_END = 9'(4 * (N_DIGITS + DELTA) - 1);
    localparam logic [6:0] N_W     = 7'(N_DIGITS);
    localparam logic [6:0] D_W     = 7'(DELTA);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STALL,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [6:0] issued_q, issued_d;
    logic       busy_q, busy_d;
    logic       we_q, we_d;
    logic       done_q, done_d;
    logic       req_q, req_d;
    logic       zf_q, zf_d;
    logic       odv_q, odv_d;
    logic       rdv_q, rdv_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        case (state_q)
            S_IDLE: begin
                cnt_d    = 9'd0;
                issued_d = 7'd0;
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                // A missed digit leaves the count on the request slot; the slot
                // completes when the digit finally arrives in STALL.
                if (req_q) begin
                    if (digit_valid) begin
                        issued_d = issued_q + 7'd1;
                        cnt_d    = cnt_q + 9'd1;
                    end else begin
                        state_d = S_STALL;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                    if (issued_q == N_W && cnt_q[1:0] == 2'b11) state_d = S_FLUSH;
                end
            end
            S_STALL: begin
                if (digit_valid) begin
                    issued_d = issued_q + 7'd1;
                    cnt_d    = cnt_q + 9'd1;
                    state_d  = S_RUN;
                end
            end
            S_FLUSH: begin
                if (cnt_q == CNT_END) state_d = S_DONE;
                else                  cnt_d   = cnt_q + 9'd1;
            end
            S_DONE: begin
                cnt_d    = 9'd0;
                issued_d = 7'd0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        we_d   = (state_d == S_RUN) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
        zf_d   = (state_d == S_FLUSH);
        req_d  = (state_d == S_STALL) ||
                 ((state_d == S_RUN) && (cnt_d[1:0] == 2'b00) && (issued_d < N_W));
        odv_d  = we_d && (cnt_d[1:0] == 2'b11) && (cnt_d[8:2] >= D_W);
        rdv_d  = rd_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 9'd0;
            issued_q <= 7'd0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
            zf_q     <= 1'b0;
            odv_q    <= 1'b0;
            rdv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            done_q   <= done_d;
            req_q    <= req_d;
            zf_q     <= zf_d;
            odv_q    <= odv_d;
            rdv_q    <= rdv_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign cnt_master      = cnt_q;
    assign write_enable    = we_q;
    assign digit_req       = req_q;
    assign zero_fill       = zf_q;
    assign out_digit_valid = odv_q;
    assign rd_data_valid   = rdv_q;

    // Host owns the RAM port only while idle.
    assign rd_grant = rd_req & ~busy_q;
    assign ram_addr = busy_q ? cc_addr : rd_addr;

endmodule

// File: tb/tb_online_mult_sequencer.sv
// Directed bench for online_mult_sequencer: default instance plus a 125/3 edge instance.
module tb_online_mult_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, digit_valid, rd_req;
    logic [6:0] cc_addr, rd_addr;
    logic       busy, done, write_enable, digit_req, zero_fill, out_digit_valid;
    logic       rd_grant, rd_data_valid;
    logic [8:0] cnt_master;
    logic [6:0] ram_addr;

    logic       start2;
    logic       busy2, done2, we2, req2, zf2, odv2, grant2, rdv2;
    logic [8:0] cnt2;
    logic [6:0] ram_addr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    online_mult_sequencer #(.N_DIGITS(32), .DELTA(3)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cnt_master(cnt_master), .write_enable(write_enable), .digit_req(digit_req),
        .digit_valid(digit_valid), .zero_fill(zero_fill), .out_digit_valid(out_digit_valid),
        .cc_addr(cc_addr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .rd_data_valid(rd_data_valid), .ram_addr(ram_addr)
    );

    online_mult_sequencer #(.N_DIGITS(125), .DELTA(3)) dut_edge (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .cnt_master(cnt2), .write_enable(we2), .digit_req(req2),
        .digit_valid(1'b1), .zero_fill(zf2), .out_digit_valid(odv2),
        .cc_addr(7'h11), .rd_req(1'b0), .rd_addr(7'h22), .rd_grant(grant2),
        .rd_data_valid(rdv2), .ram_addr(ram_addr2)
    );

    // Event counters sampled on the falling edge, cleared by the stimulus.
    logic mon_clr = 1'b1;
    int   acc_cnt, odv_cnt, first_odv, zf_cnt, done2_cnt, wrap2;
    logic [8:0] prev2;
    always @(negedge clk) begin
        if (mon_clr) begin
            acc_cnt = 0; odv_cnt = 0; first_odv = -1; zf_cnt = 0;
            done2_cnt = 0; wrap2 = 0; prev2 = 9'd0;
        end else begin
            if (digit_req && digit_valid) acc_cnt++;
            if (out_digit_valid) begin
                if (first_odv < 0) first_odv = int'(cnt_master);
                odv_cnt++;
            end
            if (zero_fill) zf_cnt++;
            if (done2) done2_cnt++;
            if (busy2) begin
                if (cnt2 < prev2) wrap2 = 1;
                prev2 = cnt2;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance until done (or the limit); n is the cycle index relative to the start edge.
    task automatic wait_done(input int n0, input int limit, output int n);
        n = n0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; digit_valid = 1'b1;
        rd_req = 1'b0; rd_addr = 7'h00; cc_addr = 7'h33;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_outputs", {busy, done, write_enable, digit_req, zero_fill,
                              out_digit_valid, rd_data_valid, rd_grant}, 32'd0);
        chk("reset_cnt", cnt_master, 32'd0);

        // Basic run
        mon_clr = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy_we_req", {busy, write_enable, digit_req}, 32'b111);
        chk("start_cnt", cnt_master, 32'd0);
        wait_done(1, 400, n);
        chk("basic_len", n, 32'd141);
        chk("basic_done_cnt", cnt_master, 32'd139);
        chk("basic_done_we", write_enable, 32'd0);
        tick();
        chk("basic_accepts", acc_cnt, 32'd32);
        chk("basic_odv", odv_cnt, 32'd32);
        chk("basic_first_odv", first_odv, 32'd15);
        chk("basic_zero_fill", zf_cnt, 32'd12);
        chk("idle_busy", busy, 32'd0);
        chk("idle_cnt", cnt_master, 32'd0);
        chk("idle_done", done, 32'd0);

        // Stall at digit 10
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n = 1;
        while (cnt_master != 9'd40 && n < 200) begin tick(); n++; end
        chk("stall_req_at_40", {write_enable, digit_req}, 32'b11);
        digit_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); n++;
            chk("stall_we_low", write_enable, 32'd0);
            chk("stall_cnt_frozen", cnt_master, 32'd40);
            chk("stall_req_held", digit_req, 32'd1);
        end
        digit_valid = 1'b1;
        tick(); n++;
        chk("stall_resume", {write_enable, digit_req}, 32'b10);
        chk("stall_resume_cnt", cnt_master, 32'd41);
        wait_done(n, 400, n);
        chk("stall_len", n, 32'd146);
        tick();
        chk("stall_accepts", acc_cnt, 32'd32);
        chk("stall_odv", odv_cnt, 32'd32);

        // Restart rules: start held high through the operation
        start = 1'b1; tick();
        wait_done(1, 400, n);
        chk("held_start_len", n, 32'd141);
        tick();
        chk("held_start_idle", {busy, write_enable}, 32'd0);
        tick();
        chk("held_start_restart", {busy, write_enable, digit_req}, 32'b111);
        chk("held_start_cnt", cnt_master, 32'd0);
        start = 1'b0;
        wait_done(1, 400, n);
        chk("restart_len", n, 32'd141);
        tick();

        // Reset mid-operation
        start = 1'b1; tick(); start = 1'b0;
        n = 1;
        while (cnt_master != 9'd70 && n < 200) begin tick(); n++; end
        chk("pre_reset_cnt", cnt_master, 32'd70);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midreset_outputs", {busy, done, write_enable, digit_req, zero_fill,
                                 out_digit_valid, rd_data_valid}, 32'd0);
        chk("midreset_cnt", cnt_master, 32'd0);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(1, 400, n);
        chk("post_reset_len", n, 32'd141);
        tick();

        // Arbitration while idle
        rd_req = 1'b1; rd_addr = 7'h15; #1;
        chk("idle_grant", rd_grant, 32'd1);
        chk("idle_ram_addr", ram_addr, 32'h15);
        tick();
        chk("idle_rdv", rd_data_valid, 32'd1);
        rd_req = 1'b0; tick();
        chk("idle_rdv_drop", rd_data_valid, 32'd0);

        // Read request in the same cycle as an accepted start
        rd_req = 1'b1; start = 1'b1; #1;
        chk("start_cycle_grant", rd_grant, 32'd1);
        tick(); start = 1'b0; #1;
        chk("start_cycle_rdv", rd_data_valid, 32'd1);
        chk("busy_grant", rd_grant, 32'd0);
        cc_addr = 7'h2a; #1;
        chk("busy_ram_addr", ram_addr, 32'h2a);
        tick();
        chk("busy_rdv", rd_data_valid, 32'd0);
        rd_req = 1'b0;
        wait_done(2, 400, n);
        chk("arb_len", n, 32'd141);
        tick();

        // Parameter edge: 125 digits, delta 3
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
        start2 = 1'b1; tick(); start2 = 1'b0;
        n = 1;
        while (!done2 && n < 700) begin tick(); n++; end
        chk("edge_len", n, 32'd513);
        chk("edge_final_cnt", cnt2, 32'd511);
        tick(); tick();
        chk("edge_no_wrap", wrap2, 32'd0);
        chk("edge_done_once", done2_cnt, 32'd1);
        chk("edge_idle", {busy2, cnt2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
